// File: rtl/retospect_cfg_loader.sv
// retospect_cfg_loader: byte stream to gap-free serial config chain loader with reset_nn arm pulse.
// Optional readback packing of bs_out_i is enabled by defining CFG_LOADER_READBACK_EN.
module retospect_cfg_loader #(
  parameter int CHAIN_LEN = 998,
  parameter int ARM_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       config_en,
  output logic       bs_in,
  input  logic       bs_out_i,
  output logic       reset_nn,
  output logic       busy,
  output logic       done,
  output logic       err_underrun
`ifdef CFG_LOADER_READBACK_EN
  ,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_mismatch
`endif
);
  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int ACW = $clog2(NBYTES + 1);
  localparam int ARW = $clog2(ARM_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, ARM, DONE, ERR} state_e;
  state_e st_q, st_d;
  logic [7:0] sh_q, sh_d, hd_q, hd_d;
  logic sh_v_q, sh_v_d, hd_v_q, hd_v_d;
  logic [2:0] bi_q, bi_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic [ACW-1:0] acc_q, acc_d;
  logic [ARW-1:0] arm_q, arm_d;
  logic go, fire, fin, last_bit;
  always_comb begin
    go = start && (st_q == IDLE || st_q == DONE || st_q == ERR);
    last_bit = bc_q == BCW'(CHAIN_LEN - 1);
    s_ready = st_q == LOAD && !hd_v_q && acc_q < ACW'(NBYTES);
    fire = s_valid && s_ready;
    fin = sh_v_q && (bi_q == 3'd7 || last_bit);
    st_d = st_q;
    sh_d = sh_q;
    hd_d = hd_q;
    sh_v_d = sh_v_q;
    hd_v_d = hd_v_q;
    bi_d = bi_q;
    bc_d = bc_q;
    acc_d = acc_q;
    arm_d = arm_q;
    case (st_q)
      LOAD: begin
        acc_d = acc_q + ACW'(fire);
        if (sh_v_q) begin
          bc_d = bc_q + 1'b1;
          bi_d = bi_q + 3'd1;
        end
        // a finishing byte refills from hold, else skids the same-cycle accept straight in
        if (fin) begin
          bi_d = 3'd0;
          if (last_bit) begin
            st_d = ARM;
            arm_d = '0;
            sh_v_d = 1'b0;
            hd_v_d = 1'b0;
          end else if (hd_v_q) begin
            sh_d = hd_q;
            hd_v_d = 1'b0;
          end else if (fire) begin
            sh_d = s_data;
          end else begin
            st_d = ERR;
            sh_v_d = 1'b0;
          end
        end else if (fire) begin
          if (sh_v_q) begin
            hd_d = s_data;
            hd_v_d = 1'b1;
          end else begin
            sh_d = s_data;
            sh_v_d = 1'b1;
            bi_d = 3'd0;
          end
        end
      end
      ARM: begin
        arm_d = arm_q + 1'b1;
        st_d = arm_q == ARW'(ARM_CYCLES - 1) ? DONE : ARM;
      end
      default: if (go) begin
        st_d = LOAD;
        bc_d = '0;
        acc_d = '0;
        bi_d = 3'd0;
        sh_v_d = 1'b0;
        hd_v_d = 1'b0;
      end
    endcase
    if (abort) begin
      st_d = IDLE;
      sh_v_d = 1'b0;
      hd_v_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      sh_q <= '0;
      hd_q <= '0;
      sh_v_q <= 1'b0;
      hd_v_q <= 1'b0;
      bi_q <= '0;
      bc_q <= '0;
      acc_q <= '0;
      arm_q <= '0;
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      hd_q <= hd_d;
      sh_v_q <= sh_v_d;
      hd_v_q <= hd_v_d;
      bi_q <= bi_d;
      bc_q <= bc_d;
      acc_q <= acc_d;
      arm_q <= arm_d;
    end
  end
  assign config_en = sh_v_q;
  assign bs_in = sh_v_q & sh_q[bi_q];
  assign reset_nn = st_q == ARM;
  assign busy = st_q == LOAD || st_q == ARM;
  assign done = st_q == DONE;
  assign err_underrun = st_q == ERR;
`ifdef CFG_LOADER_READBACK_EN
  logic [7:0] pk_q, pk_d, pk_nx, rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d;
  // the returned bit sits at the same position as the bit being sent, so bi doubles as pack index
  always_comb begin
    pk_nx = pk_q | (8'(bs_out_i) << bi_q);
    rd_valid_d = fin && !abort;
    rd_data_d = rd_valid_d ? pk_nx : rd_data_q;
    pk_d = (fin || go || abort) ? 8'h00 : config_en ? pk_nx : pk_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pk_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      pk_q <= pk_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_mismatch = 1'b0;
`else
  logic unused_bs_out;
  assign unused_bs_out = bs_out_i;
`endif
endmodule

// File: tb/tb_retospect_cfg_loader.sv
// tb_retospect_cfg_loader: scoreboard bench; dut_a uses a 16-bit chain, dut_b the full 998-bit chain.
module tb_retospect_cfg_loader;
  logic clk = 1'b0;
  logic reset;
  logic start[2];
  logic abort_i[2];
  logic [7:0] s_data[2];
  logic s_valid[2];
  logic s_ready[2];
  logic cfg_en[2];
  logic bs[2];
  logic bso[2];
  logic rnn_o[2];
  logic busy[2];
  logic done[2];
  logic err[2];
  int len[2] = '{16, 998};
  bit exp_q[2][$];
  int qd[2];
  int cen[2];
  int hs[2];
  int rnn[2];
  int gap[2];
  int last_cen[2];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [15:0] chain = '0;
  always #5 clk = ~clk;
  always @(posedge clk) if (cfg_en[0]) chain <= {bs[0], chain[15:1]};
  assign bso[0] = chain[0];
  assign bso[1] = 1'b0;
`ifdef CFG_LOADER_READBACK_EN
  logic [7:0] rd_data_a, rd_data_b;
  logic rd_valid_a, rd_valid_b, rd_mm_a, rd_mm_b;
  bit rd_chk = 0;
  int rd_cnt = 0;
  logic [7:0] exp_rd[$];
`endif
  retospect_cfg_loader #(.CHAIN_LEN(16), .ARM_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort_i[0]),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .config_en(cfg_en[0]), .bs_in(bs[0]), .bs_out_i(bso[0]), .reset_nn(rnn_o[0]),
    .busy(busy[0]), .done(done[0]), .err_underrun(err[0])
`ifdef CFG_LOADER_READBACK_EN
    , .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_mismatch(rd_mm_a)
`endif
  );
  retospect_cfg_loader dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort_i[1]),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .config_en(cfg_en[1]), .bs_in(bs[1]), .bs_out_i(bso[1]), .reset_nn(rnn_o[1]),
    .busy(busy[1]), .done(done[1]), .err_underrun(err[1])
`ifdef CFG_LOADER_READBACK_EN
    , .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_mismatch(rd_mm_b)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_valid[i] && s_ready[i]) hs[i]++;
      if (rnn_o[i]) rnn[i]++;
      if (cfg_en[i]) begin
        if (cen[i] > 0 && last_cen[i] != cyc - 1) gap[i]++;
        last_cen[i] = cyc;
        cen[i]++;
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bs_in%0d: config_en high with no expected bit", i);
        end else chk($sformatf("bs_in%0d_bit%0d", i, cen[i] - 1), 32'(bs[i]), 32'(exp_q[i].pop_front()));
      end
    end
`ifdef CFG_LOADER_READBACK_EN
    if (rd_chk && rd_valid_a) begin
      rd_cnt++;
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data: unexpected rd_valid data %0h", rd_data_a);
      end else chk("rd_data", 32'(rd_data_a), 32'(exp_rd.pop_front()));
    end
`endif
    cyc++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic kick(input int i);
    start[i] = 1'b1;
    cen[i] = 0;
    hs[i] = 0;
    rnn[i] = 0;
    gap[i] = 0;
    qd[i] = 0;
    exp_q[i].delete();
    tick();
    start[i] = 1'b0;
  endtask
  task automatic push(input int i, input logic [7:0] d);
    int n = 0;
    s_data[i] = d;
    s_valid[i] = 1'b1;
    while (!s_ready[i] && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL push%0d: s_ready stuck 0 want 1", i);
      s_valid[i] = 1'b0;
      return;
    end
    tick();
    for (int k = 0; k < 8; k++) if (qd[i] < len[i]) begin
      exp_q[i].push_back(d[k]);
      qd[i]++;
    end
    s_valid[i] = 1'b0;
  endtask
  task automatic wait_end(input int i, input int max);
    int n = 0;
    while (!done[i] && !err[i] && n < max) begin
      tick();
      n++;
    end
    if (n == max) begin
      checks++;
      errors++;
      $display("FAIL timeout%0d: no done/err after %0d cycles want done or err", i, max);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      abort_i[i] = 1'b0;
      s_data[i] = 8'h00;
      s_valid[i] = 1'b0;
    end
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_outs%0d", i), 32'({s_ready[i], cfg_en[i], bs[i], busy[i], done[i], err[i], rnn_o[i]}), 0);
    // reset held two cycles in the middle of a load
    kick(0);
    push(0, 8'hFF);
    push(0, 8'h00);
    repeat (3) tick();
    s_data[0] = 8'h55;
    s_valid[0] = 1'b1;
    reset = 1'b1;
    tick();
    exp_q[0].delete();
    tick();
    reset = 1'b0;
    chk("rst_mid_outs", 32'({s_ready[0], cfg_en[0], bs[0], busy[0], done[0], err[0], rnn_o[0]}), 0);
    tick();
    chk("rst_mid_idle_ready", 32'({s_ready[0], busy[0]}), 0);
    s_valid[0] = 1'b0;
    // back-to-back A5, 3C on the 16-bit chain
    kick(0);
    push(0, 8'hA5);
    push(0, 8'h3C);
    wait_end(0, 40);
    chk("b2b_done_err", 32'({done[0], err[0], busy[0]}), 32'b100);
    chk("b2b_cen_cycles", cen[0], 16);
    chk("b2b_reset_nn", rnn[0], 1);
    chk("b2b_gaps", gap[0], 0);
    chk("b2b_queue_left", exp_q[0].size(), 0);
    // restart from DONE: done drops with the start edge, no byte yet is not an error
    kick(0);
    chk("restart_done_busy", 32'({done[0], busy[0]}), 32'b01);
    repeat (5) tick();
    chk("nobyte_wait", 32'({err[0], cfg_en[0], busy[0]}), 32'b001);
    push(0, 8'h12);
    push(0, 8'h34);
    wait_end(0, 40);
    chk("load1234_done", 32'(done[0]), 1);
`ifdef CFG_LOADER_READBACK_EN
    rd_chk = 1;
    rd_cnt = 0;
    exp_rd.push_back(8'h12);
    exp_rd.push_back(8'h34);
    kick(0);
    push(0, 8'h00);
    push(0, 8'h00);
    wait_end(0, 40);
    rd_chk = 0;
    chk("rd_count", rd_cnt, 2);
    chk("rd_left", exp_rd.size(), 0);
    chk("rd_mismatch", 32'(rd_mm_a), 0);
`endif
    // underrun: third byte withheld on the full chain
    kick(1);
    push(1, 8'h0F);
    push(1, 8'hF0);
    wait_end(1, 60);
    repeat (9) tick();
    s_data[1] = 8'h77;
    s_valid[1] = 1'b1;
    #1;
    chk("underrun_no_ready", 32'(s_ready[1]), 0);
    s_valid[1] = 1'b0;
    chk("underrun_flags", 32'({done[1], err[1], busy[1]}), 32'b010);
    chk("underrun_cen", cen[1], 16);
    chk("underrun_no_arm", rnn[1], 0);
    // abort around bit 40
    kick(1);
    chk("start_from_err", 32'({err[1], busy[1]}), 32'b01);
    for (int j = 0; j < 6; j++) push(1, 8'(j * 17 + 3));
    for (int n = 0; n < 100 && cen[1] < 40; n++) tick();
    chk("abort_reached40", 32'(cen[1] >= 40), 1);
    abort_i[1] = 1'b1;
    tick();
    abort_i[1] = 1'b0;
    exp_q[1].delete();
    chk("abort_outs", 32'({cfg_en[1], s_ready[1], busy[1], done[1], err[1], rnn_o[1]}), 0);
    // clean full load with s_valid held high
    kick(1);
    for (int j = 0; j < 125; j++) push(1, j == 124 ? 8'hFF : 8'(j * 37 + 11));
    s_data[1] = 8'hAA;
    s_valid[1] = 1'b1;
    #1;
    chk("full_no_extra_ready", 32'({s_ready[1], busy[1]}), 32'b01);
    s_valid[1] = 1'b0;
    wait_end(1, 1200);
    chk("full_done", 32'({done[1], err[1]}), 32'b10);
    chk("full_cen", cen[1], 998);
    chk("full_handshakes", hs[1], 125);
    chk("full_reset_nn", rnn[1], 1);
    chk("full_gaps", gap[1], 0);
    chk("full_queue_left", exp_q[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/retospect_cfg_loader.md
Name: retospect_cfg_loader

Overview:
- Byte-wide configuration sequencer for the neurochip fabric. It sits between a host byte stream and the serial config chain: the clockbox followed by all cnb cells.
- It accepts bytes over a valid/ready handshake and serializes them LSB-first onto bs_in while holding config_en.
- Shifting runs without gaps, because any config_en-low cycle lets cells integrate dendrites. After the load it issues the reset_nn arm pulse and reports done or error.

Parameters:
- CHAIN_LEN, 998, total chain bits: 6 clock_max x 8 bits, plus 50 cells x 19 bits.
- ARM_CYCLES, 1, length of the reset_nn pulse after load, in cycles (>=1).
- NBYTES, (CHAIN_LEN+7)/8, bytes consumed per load (localparam).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE, DONE, ERR
- abort  in  1  return to IDLE next cycle from any state
- s_data  in  8  config byte; bit0 is shifted first
- s_valid  in  1  s_data valid
- s_ready  out  1  byte accepted when s_valid&s_ready
- config_en  out  1  chain shift enable
- bs_in  out  1  serial bit into chain
- bs_out_i  in  1  serial bit returned from chain end
- reset_nn  out  1  neuron potential preset pulse
- busy  out  1  state is LOAD or ARM
- done  out  1  level, load completed
- err_underrun  out  1  level, load aborted by starvation

Behaviour:
- Reset (sync, active-high): state IDLE. All outputs 0. Counters and buffers cleared. Reset overrides every other input.
- Storage:
  - shift reg sh[7:0] with valid flag and bit index bi (0..7);
  - hold reg hd[7:0] with valid flag;
  - bit counter bc, width $clog2(CHAIN_LEN+1), counting bits sent;
  - byte counter acc, counting bytes accepted.
- FSM IDLE/LOAD/ARM/DONE/ERR:
  - IDLE: start=1 -> LOAD; bc, acc, bi := 0.
  - LOAD:
    - s_ready = !hd_valid && acc<NBYTES.
    - An accepted byte goes to sh if sh is empty or finishing this cycle; otherwise it goes to hd.
    - Each cycle sh_valid=1: config_en=1, bs_in=sh[bi], bi++, bc++.
    - On bi==7 or bc==CHAIN_LEN-1: sh is reloaded from hd (or from a same-cycle accept, skid-through) and bi := 0.
  - Latency: first accepted byte -> config_en=1 and bs_in=s_data[0] the following cycle.
  - Before the first byte arrives in LOAD, config_en stays 0; this is not an error.
  - Completion: bc reaches CHAIN_LEN -> config_en=0 next cycle, state ARM.
    - Exactly CHAIN_LEN config_en-high cycles per load.
    - Unused upper bits of the final byte are discarded.
  - Underrun: sh finishes a byte, bc<CHAIN_LEN, and neither hd nor a same-cycle accept is available -> next cycle config_en=0, state ERR. Partial chain contents are left as-is.
  - ARM: reset_nn=1 for ARM_CYCLES cycles, then DONE.
  - DONE: done=1. start -> LOAD (done clears the same cycle).
  - ERR: err_underrun=1. start -> LOAD.
- Chain ordering: the first bit shifted ends at the chain tail (last cell clockDecaySelect[0]). The last bit lands in clockbox clock_max[0][7].
- Handshake:
  - s_ready never asserts outside LOAD.
  - Bytes beyond NBYTES are not accepted.
  - s_data is captured only on handshake.
- abort: highest priority after reset. Next cycle state IDLE; config_en, reset_nn, s_ready = 0; buffers are dropped; done and err are cleared.
- start while busy: ignored.
- busy = LOAD|ARM.

Optional Feature:
- Macro: CFG_LOADER_READBACK_EN. When defined, adds these ports:
  - rd_data out 8;
  - rd_valid out 1;
  - rd_mismatch out 1 (sticky until start).
- Each config_en-high cycle samples bs_out_i into a packing register, LSB first.
- Every 8th sampled bit, and at the final bit with zero-padding, rd_valid pulses 1 cycle with the packed byte. There is no backpressure.
- This yields the previous chain contents, enabling readback by loading twice.
- rd_mismatch is reserved-0 unless a compare image is loaded; it is fixed 0 in this revision.
- When the macro is undefined: ports are absent, bs_out_i is unused, and there is no packing logic.

Test Plan:
- Reset held 2 cycles mid-LOAD -> next cycle all outputs 0, state IDLE; s_ready=0 even with s_valid=1.
- Back-to-back bytes 0xA5 then 0x3C with CHAIN_LEN=16 -> bs_in sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on 16 consecutive config_en cycles; then reset_nn=1 for 1 cycle; then done=1.
- Full 998-bit load with s_valid always 1 -> exactly 998 config_en cycles, 125 handshakes, final 2 bits of byte 125 discarded, done=1.
- Withhold the 3rd byte until 9 cycles after byte 2 completes -> config_en drops after bit 16; err_underrun=1; no reset_nn pulse.
- abort asserted at bit 40 -> next cycle config_en=0, s_ready=0, state IDLE; a following start performs a clean full load.
- READBACK_EN, CHAIN_LEN=16: load 0x12,0x34, then load 0x00,0x00 -> second load emits rd_valid twice with rd_data 0x12 then 0x34.
